// File: rtl/seg_display_hub_pkg.sv
// seg_display_hub_pkg: FSM states, segment code table and sizing helper shared by the display hub
package seg_display_hub_pkg;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // active-low, bit0=a .. bit6=g; glyphs 0-9, A, b, C, d, E, F
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/seg_display_hub_seg7_encode.sv
// seg7_encode: one digit nibble plus blank flag to an active-low seven-segment code
module seg7_encode
    import seg_display_hub_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : SEG_CODES[digit_i];

endmodule

// File: rtl/seg_display_hub.sv
// seg_display_hub: hex/decimal seven-segment driver with serial double-dabble and a one-deep pending load
module seg_display_hub
    import seg_display_hub_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   value_in,
    input  logic                    mode_dec,
    input  logic                    blank_lz,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] segs
);

    localparam int BCD_DIGITS = (DATA_WIDTH * 3) / 10 + 1;
    localparam int SCR_DIGITS = max2(BCD_DIGITS, NUM_DIGITS);
    localparam int SW         = 4 * SCR_DIGITS;
    localparam int CW         = $clog2(DATA_WIDTH + 1);

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   sh_q;
    logic [SW-1:0]           scr_q, adj, scr_d;
    logic [CW-1:0]           cnt_q;
    logic                    blz_q;
    logic                    pend_v_q, pend_dec_q, pend_blz_q;
    logic [DATA_WIDTH-1:0]   pend_val_q;
    logic [7*NUM_DIGITS-1:0] segs_q, code;
    logic                    done_q, ovf_q;
    logic [SCR_DIGITS-1:0]   nz;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    ovf;
    logic                    start_v, st_dec, st_blz;
    logic [DATA_WIDTH-1:0]   st_val;

    // a waiting pending request beats a load arriving in the same idle cycle
    assign start_v = pend_v_q | load;
    assign st_val  = pend_v_q ? pend_val_q : value_in;
    assign st_dec  = pend_v_q ? pend_dec_q : mode_dec;
    assign st_blz  = pend_v_q ? pend_blz_q : blank_lz;

    for (genvar i = 0; i < SCR_DIGITS; i++) begin : g_scr
        assign nz[i] = |scr_q[4*i +: 4];
        assign adj[4*i +: 4] = scr_q[4*i +: 4] >= 4'd5 ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
    end

    assign scr_d = SW'({adj, sh_q[DATA_WIDTH-1]});
    assign ovf   = |(nz >> NUM_DIGITS);

    // digit 0 is never blanked so a zero value still reads "0"
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_enc
        assign blank[i] = blz_q & (i != 0) & ~|nz[SCR_DIGITS-1:i];
        seg7_encode u_enc (
            .digit_i (scr_q[4*i +: 4]),
            .blank_i (blank[i]),
            .seg_o   (code[7*i +: 7])
        );
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            sh_q       <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            blz_q      <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_dec_q <= 1'b0;
            pend_blz_q <= 1'b0;
            pend_val_q <= '0;
            segs_q     <= '1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load && (state_q != S_IDLE || pend_v_q)) begin
                pend_v_q   <= 1'b1;
                pend_val_q <= value_in;
                pend_dec_q <= mode_dec;
                pend_blz_q <= blank_lz;
            end else if (state_q == S_IDLE) begin
                pend_v_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: if (start_v) begin
                    scr_q   <= st_dec ? '0 : SW'(st_val);
                    sh_q    <= st_val;
                    cnt_q   <= CW'(DATA_WIDTH);
                    blz_q   <= st_blz;
                    state_q <= st_dec ? S_CONV : S_COMMIT;
                end
                S_CONV: begin
                    scr_q   <= scr_d;
                    sh_q    <= sh_q << 1;
                    cnt_q   <= cnt_q - CW'(1);
                    state_q <= cnt_q == CW'(1) ? S_COMMIT : S_CONV;
                end
                S_COMMIT: begin
                    segs_q  <= code;
                    ovf_q   <= ovf;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = state_q != S_IDLE;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign segs     = segs_q;

endmodule

// File: tb/tb_seg_display_hub.sv
// tb_seg_display_hub: table-driven vectors plus pending-buffer and mid-conversion reset sequences
module tb_seg_display_hub;

    logic        clock;
    logic        resetn;
    logic [31:0] value_in;
    logic        mode_dec;
    logic        blank_lz;
    logic        load;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [55:0] segs;

    int pass_cnt = 0;
    int total_cnt = 0;

    seg_display_hub #(.DATA_WIDTH(32), .NUM_DIGITS(8)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .value_in (value_in),
        .mode_dec (mode_dec),
        .blank_lz (blank_lz),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .segs     (segs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    typedef struct packed {
        logic [31:0] val;
        logic        dec;
        logic        blz;
        logic [55:0] segs;
        logic        ovf;
    } vec_t;

    function automatic logic [6:0] code_of(input byte c);
        case (c)
            "0": return 7'h40;
            "1": return 7'h79;
            "2": return 7'h24;
            "3": return 7'h30;
            "4": return 7'h19;
            "5": return 7'h12;
            "6": return 7'h02;
            "7": return 7'h78;
            "8": return 7'h00;
            "9": return 7'h10;
            "A": return 7'h08;
            "b": return 7'h03;
            "C": return 7'h46;
            "d": return 7'h21;
            "E": return 7'h06;
            "F": return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // leftmost character is digit 7, space means blank
    function automatic logic [55:0] exp_segs(input string s);
        logic [55:0] r;
        r = '1;
        for (int k = 0; k < 8; k++) r[7*k +: 7] = code_of(s[7-k]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc, bsy;
        @(negedge clock);
        value_in = v.val;
        mode_dec = v.dec;
        blank_lz = v.blz;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        cyc = 1;
        bsy = int'(busy);
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            bsy += int'(busy);
        end
        chk({nm, " latency"}, 64'(cyc), v.dec ? 64'd34 : 64'd2);
        chk({nm, " busy cycles"}, 64'(bsy), v.dec ? 64'd33 : 64'd1);
        chk({nm, " segs"}, 64'(segs), 64'(v.segs));
        chk({nm, " overflow"}, 64'(overflow), 64'(v.ovf));
    endtask

    vec_t vecs [11];
    logic [55:0] got [2];
    int nd, t2;

    initial begin
        vecs[0]  = '{32'h0000002B, 1'b0, 1'b0, exp_segs("0000002b"), 1'b0};
        vecs[1]  = '{32'd255,      1'b1, 1'b1, exp_segs("     255"), 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 1'b1, 1'b0, exp_segs("94967295"), 1'b1};
        vecs[3]  = '{32'hDEADBEEF, 1'b0, 1'b0, exp_segs("dEAdbEEF"), 1'b0};
        vecs[4]  = '{32'h00000000, 1'b0, 1'b1, exp_segs("       0"), 1'b0};
        vecs[5]  = '{32'd0,        1'b1, 1'b1, exp_segs("       0"), 1'b0};
        vecs[6]  = '{32'd99999999, 1'b1, 1'b1, exp_segs("99999999"), 1'b0};
        vecs[7]  = '{32'd100000000,1'b1, 1'b1, exp_segs("00000000"), 1'b1};
        vecs[8]  = '{32'h00012C0F, 1'b0, 1'b1, exp_segs("   12C0F"), 1'b0};
        vecs[9]  = '{32'd1234567,  1'b1, 1'b0, exp_segs("01234567"), 1'b0};
        vecs[10] = '{32'd10,       1'b1, 1'b1, exp_segs("      10"), 1'b0};

        value_in = '0;
        mode_dec = 1'b0;
        blank_lz = 1'b0;
        load = 1'b0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        chk("reset segs", 64'(segs), 64'h00FF_FFFF_FFFF_FFFF);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset overflow", 64'(overflow), 64'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // 12 starts, 99 and then 7 land in pending; only 7 survives
        nd = 0;
        t2 = -1;
        for (int t = 0; t < 120; t++) begin
            @(negedge clock);
            if (done) begin
                if (nd < 2) got[nd] = segs;
                if (nd == 1) t2 = t;
                nd++;
            end
            load = (t == 0 || t == 5 || t == 10);
            value_in = t == 0 ? 32'd12 : t == 5 ? 32'd99 : 32'd7;
            mode_dec = 1'b1;
            blank_lz = 1'b1;
        end
        load = 1'b0;
        chk("pending done count", 64'(nd), 64'd2);
        chk("pending first value", 64'(got[0]), 64'(exp_segs("      12")));
        chk("pending second value", 64'(got[1]), 64'(exp_segs("       7")));
        chk("pending second timing", 64'(t2), 64'd68);

        @(negedge clock);
        value_in = 32'd255;
        mode_dec = 1'b1;
        blank_lz = 1'b1;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (10) @(negedge clock);
        chk("midconv busy", 64'(busy), 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("midconv reset segs", 64'(segs), 64'h00FF_FFFF_FFFF_FFFF);
        chk("midconv reset busy", 64'(busy), 64'd0);
        chk("midconv reset done", 64'(done), 64'd0);
        chk("midconv reset overflow", 64'(overflow), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        run_vec('{32'd0, 1'b1, 1'b0, exp_segs("00000000"), 1'b0}, "post reset zero");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
